// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with hex font, per-digit dp/blank and frame-boundary double buffering.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned CNT_SCAN       = 50000,
    parameter int unsigned SEL_ACTIVE_LOW = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk_50mhz,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   dis_data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int unsigned CNT_W  = (CNT_SCAN > 1) ? $clog2(CNT_SCAN) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_SCAN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shd_data_q, shd_data_d;
    logic [DIGITS-1:0] shd_dp_q, shd_dp_d;
    logic [DIGITS-1:0] shd_blank_q, shd_blank_d;
    logic [DATA_W-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0] act_dp_q, act_dp_d;
    logic [DIGITS-1:0] act_blank_q, act_blank_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;
    logic              frame_done_q, frame_done_d;

    logic              tick;
    logic              wrap;
    logic [3:0]        cur_nib;
    logic              cur_dark;
    logic [7:0]        cur_seg_al;
    logic [DIGITS-1:0] lz_mask;

    // Hex font, active-low, dp off.
    function automatic logic [7:0] font_al(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'h0: f = 8'hC0;
            4'h1: f = 8'hF9;
            4'h2: f = 8'hA4;
            4'h3: f = 8'hB0;
            4'h4: f = 8'h99;
            4'h5: f = 8'h92;
            4'h6: f = 8'h82;
            4'h7: f = 8'hF8;
            4'h8: f = 8'h80;
            4'h9: f = 8'h90;
            4'hA: f = 8'h88;
            4'hB: f = 8'h83;
            4'hC: f = 8'hC6;
            4'hD: f = 8'hA1;
            4'hE: f = 8'h86;
            default: f = 8'h8E;
        endcase
        return f;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic nz_seen;
        nz_seen = 1'b0;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (act_data_q[4*i +: 4] != 4'h0) begin
                nz_seen = 1'b1;
            end
            lz_mask[i] = ~nz_seen;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shd_data_d   = shd_data_q;
        shd_dp_d     = shd_dp_q;
        shd_blank_d  = shd_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        sel_d        = SEL_OFF;
        seg_d        = SEG_OFF;
        frame_done_d = 1'b0;

        tick       = (cnt_q == CNT_LAST);
        wrap       = tick && (idx_q == IDX_LAST);
        cur_nib    = act_data_q[4*int'(idx_q) +: 4];
        cur_dark   = act_blank_q[idx_q] | lz_mask[idx_q];
        cur_seg_al = font_al(cur_nib) & {~act_dp_q[idx_q], 7'h7F};

        if (load) begin
            shd_data_d  = dis_data;
            shd_dp_d    = dp;
            shd_blank_d = blank;
        end

        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                idx_d = wrap ? '0 : idx_q + IDX_W'(1);
            end
            // Active data only changes at the frame boundary so a frame never tears.
            if (wrap) begin
                act_data_d   = shd_data_q;
                act_dp_d     = shd_dp_q;
                act_blank_d  = shd_blank_q;
                frame_done_d = 1'b1;
            end
            if (!cur_dark) begin
                sel_d = SEL_OFF ^ (DIGITS'(1) << idx_q);
                seg_d = cur_seg_al ^ ~SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            sel_q        <= SEL_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shd_data_q   <= shd_data_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 8 digits, 10 clocks per slot, active-low sel and seg.
// Define SEG7_LZ_BLANK_EN for both files to exercise leading-zero suppression.
module tb_seg7_scan_driver;

    logic        clk_50mhz = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] dis_data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] nxt_data;
    logic [7:0]  nxt_dp;
    logic [7:0]  nxt_blank;

    always #5 clk_50mhz = ~clk_50mhz;

    seg7_scan_driver #(
        .DIGITS         (8),
        .CNT_SCAN       (10),
        .SEL_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .dis_data   (dis_data),
        .dp         (dp),
        .blank      (blank),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    // Expected segment patterns, digit 7 in the top byte; FF marks a dark digit.
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [63:0] PAT_ZERO = 64'hFFFFFFFF_FFFFFFC0;
    localparam logic [63:0] PAT_A05  = 64'hFFFFFFFF_FF88C092;
`else
    localparam logic [63:0] PAT_ZERO = 64'hC0C0C0C0_C0C0C0C0;
    localparam logic [63:0] PAT_A05  = 64'hC0C0C0C0_C088C092;
`endif
    localparam logic [63:0] PAT_12345678 = 64'hF9A4B099_9282F880;
    localparam logic [63:0] PAT_87654321 = 64'h80F88292_99B0A4F9;
    localparam logic [63:0] PAT_89ABCDEF = 64'hFF908883_46A1868E;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at the negedge following a frame boundary; optionally loads nxt_* at cycle ld_off.
    task automatic run_frame(input string name, input logic [63:0] exp_seg, input int ld_off);
        int         d;
        logic [7:0] eseg;
        logic [7:0] esel;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk_50mhz);
            load = 1'b0;
            if (c == ld_off) begin
                dis_data = nxt_data;
                dp       = nxt_dp;
                blank    = nxt_blank;
                load     = 1'b1;
            end
            if ((c % 10) == 1 || (c % 10) == 0) begin
                d    = (c - 1) / 10;
                eseg = exp_seg[8*d +: 8];
                esel = (eseg == 8'hFF) ? 8'hFF : ~(8'h01 << d);
                check($sformatf("%s_c%0d_sel", name, c), sel, esel);
                check($sformatf("%s_c%0d_seg", name, c), seg, eseg);
            end
            if (c == 1 || c == 79) check($sformatf("%s_c%0d_fd", name, c), frame_done, 1'b0);
            if (c == 80)           check($sformatf("%s_c80_fd", name), frame_done, 1'b1);
        end
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_50mhz);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        check("fd_wait", frame_done, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        dis_data = '0;
        dp       = '0;
        blank    = '0;
        nxt_data = '0;
        nxt_dp   = '0;
        nxt_blank = '0;

        repeat (3) @(negedge clk_50mhz);
        check("rst_sel", sel, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check("rst_fd", frame_done, 1'b0);

        // Release reset and load 12345678 on the same edge; first frame still shows cleared data.
        rst_n    = 1'b1;
        load     = 1'b1;
        dis_data = 32'h12345678;
        nxt_data = 32'h87654321;
        run_frame("f_zero", PAT_ZERO, 0);

        // Mid-frame load must not disturb the frame being shown.
        run_frame("f_1234", PAT_12345678, 35);

        // Load on the boundary edge: active takes the old shadow, new data one frame later.
        nxt_data  = 32'h89ABCDEF;
        nxt_dp    = 8'h08;
        nxt_blank = 8'h80;
        run_frame("f_8765a", PAT_87654321, 79);
        run_frame("f_8765b", PAT_87654321, 0);
        run_frame("f_89ab", PAT_89ABCDEF, 0);

        // Disable mid digit 3, then re-enable: digit 0 gets a full slot.
        repeat (35) @(negedge clk_50mhz);
        check("en_pre_sel", sel, 8'hF7);
        check("en_pre_seg", seg, 8'h46);
        en = 1'b0;
        @(negedge clk_50mhz);
        check("en0_sel", sel, 8'hFF);
        check("en0_seg", seg, 8'hFF);
        repeat (3) @(negedge clk_50mhz);
        check("en0_hold_sel", sel, 8'hFF);
        check("en0_hold_fd", frame_done, 1'b0);
        en = 1'b1;
        @(negedge clk_50mhz);
        check("en1_first_sel", sel, 8'hFE);
        check("en1_first_seg", seg, 8'h8E);
        repeat (9) @(negedge clk_50mhz);
        check("en1_last_sel", sel, 8'hFE);
        @(negedge clk_50mhz);
        check("en1_next_sel", sel, 8'hFD);
        check("en1_next_seg", seg, 8'h86);
        wait_fd(200);

        // Zero-heavy data: zeros shown as C0 or suppressed depending on build.
        nxt_data  = 32'h00000A05;
        nxt_dp    = 8'h00;
        nxt_blank = 8'h00;
        run_frame("f_89ab2", PAT_89ABCDEF, 5);
        nxt_data  = 32'h00000000;
        run_frame("f_a05", PAT_A05, 5);
        run_frame("f_zero2", PAT_ZERO, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
